clint_trap_ctrl: RTL and testbench

Machine-mode trap sequencer: the initiating side of the CSR file's clint write port. It detects a pending machine timer interrupt, an `ecall`, or an `mret` at the commit point and holds the pipeline. It then writes mepc, mcause and mstatus one per cycle through the single clint CSR write port, and finally issues a PC redirect and flush. It sits between the commit stage, the CSR file and the IF stage.

---
 rtl/clint_trap_ctrl_pkg.sv | 13 +
 rtl/clint_trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clint_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_trap_ctrl_pkg.sv
// Shared CSR addresses and trap cause codes for the machine-mode trap sequencer.
package clint_trap_ctrl_pkg;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  // Interrupt bit set, code 7 = machine timer interrupt.
  localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;
  // Code 11 = environment call from M-mode.
  localparam logic [63:0] CAUSE_ECALL_M = 64'h0000_0000_0000_000B;

endpackage

// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap sequencer. It takes a timer interrupt, ecall or mret at
// commit and holds the pipe. It writes mepc/mcause/mstatus one per cycle
// through the shared clint CSR port, then issues a redirect/flush pulse.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  input  logic        cpu_csr_wen_i,
  output logic        clint_csr_wen_o,
  output logic [11:0] clint_csr_waddr_o,
  output logic [63:0] clint_csr_wdata_o,
  output logic        hold_pipe_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic        int_ack_o
);

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_W_MEPC        = 3'd1;
  localparam logic [2:0] S_W_MCAUSE      = 3'd2;
  localparam logic [2:0] S_W_MSTATUS     = 3'd3;
  localparam logic [2:0] S_W_MSTATUS_RET = 3'd4;
  localparam logic [2:0] S_REDIRECT      = 3'd5;

  // Trap entry: stash MIE into MPIE, disable interrupts, MPP = M.
  function automatic logic [63:0] mstatus_enter(input logic [63:0] s);
    logic [63:0] r;
    r       = s;
    r[7]    = s[3];
    r[3]    = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP stays M.
  function automatic logic [63:0] mstatus_return(input logic [63:0] s);
    logic [63:0] r;
    r       = s;
    r[3]    = s[7];
    r[7]    = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic int_take, trig_int, trig_ecall, trig_mret;
  logic [63:0] tvec_base;

  // Trigger priority: interrupt, then ecall, then mret.
  assign int_take   = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
  assign trig_int   = inst_valid_i & int_take;
  assign trig_ecall = inst_valid_i & ecall_i & ~int_take;
  assign trig_mret  = inst_valid_i & mret_i & ~int_take & ~ecall_i;
  assign tvec_base  = {csr_mtvec_i[63:2], 2'b00};

  // State and trap context registers; sync reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // Next state; W_* states stall while the CPU owns the CSR write port.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      S_IDLE: begin
        if (trig_int | trig_ecall) begin
          epc_d   = inst_pc_i;
          cause_d = trig_int ? CAUSE_MTIMER : CAUSE_ECALL_M;
          mret_d  = 1'b0;
          state_d = S_W_MEPC;
        end else if (trig_mret) begin
          mret_d  = 1'b1;
          state_d = S_W_MSTATUS_RET;
        end
      end
      S_W_MEPC:        if (!cpu_csr_wen_i) state_d = S_W_MCAUSE;
      S_W_MCAUSE:      if (!cpu_csr_wen_i) state_d = S_W_MSTATUS;
      S_W_MSTATUS:     if (!cpu_csr_wen_i) state_d = S_REDIRECT;
      S_W_MSTATUS_RET: if (!cpu_csr_wen_i) state_d = S_REDIRECT;
      S_REDIRECT:      state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Outputs; IDLE terms are combinational on the trigger so the pipe stalls at once.
  always_comb begin
    clint_csr_wen_o   = 1'b0;
    clint_csr_waddr_o = '0;
    clint_csr_wdata_o = '0;
    hold_pipe_o       = 1'b0;
    redirect_valid_o  = 1'b0;
    redirect_pc_o     = '0;
    int_ack_o         = 1'b0;
    case (state_q)
      S_IDLE: begin
        hold_pipe_o = trig_int | trig_ecall | trig_mret;
        int_ack_o   = trig_int;
      end
      S_W_MEPC: begin
        hold_pipe_o       = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MEPC;
        clint_csr_wdata_o = epc_q;
      end
      S_W_MCAUSE: begin
        hold_pipe_o       = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MCAUSE;
        clint_csr_wdata_o = cause_q;
      end
      S_W_MSTATUS: begin
        hold_pipe_o       = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MSTATUS;
        clint_csr_wdata_o = mstatus_enter(csr_mstatus_i);
      end
      S_W_MSTATUS_RET: begin
        hold_pipe_o       = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MSTATUS;
        clint_csr_wdata_o = mstatus_return(csr_mstatus_i);
      end
      S_REDIRECT: begin
        hold_pipe_o      = 1'b1;
        redirect_valid_o = 1'b1;
        // cause_q[63] marks an interrupt; only those use vectored mode.
        if (mret_q)
          redirect_pc_o = csr_mepc_i;
        else if (cause_q[63] && csr_mtvec_i[1:0] == 2'b01)
          redirect_pc_o = tvec_base + {cause_q[61:0], 2'b00};
        else
          redirect_pc_o = tvec_base;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Scoreboard bench for clint_trap_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_clint_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [63:0] inst_pc_i;
  logic        ecall_i;
  logic        mret_i;
  logic        global_int_en_i;
  logic        mtime_int_en_i;
  logic        mtime_int_pend_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        cpu_csr_wen_i;
  logic        clint_csr_wen_o;
  logic [11:0] clint_csr_waddr_o;
  logic [63:0] clint_csr_wdata_o;
  logic        hold_pipe_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        int_ack_o;

  clint_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
    .ecall_i(ecall_i), .mret_i(mret_i),
    .global_int_en_i(global_int_en_i), .mtime_int_en_i(mtime_int_en_i),
    .mtime_int_pend_i(mtime_int_pend_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .cpu_csr_wen_i(cpu_csr_wen_i),
    .clint_csr_wen_o(clint_csr_wen_o), .clint_csr_waddr_o(clint_csr_waddr_o),
    .clint_csr_wdata_o(clint_csr_wdata_o), .hold_pipe_o(hold_pipe_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .int_ack_o(int_ack_o)
  );

  localparam int K_ACK = 0, K_WR = 1, K_RD = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [11:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t ev_q[$];
  bit  hold_q[$];
  int  cyc = 0;
  int  passes = 0;
  int  total = 0;
  bit  mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int kind, input logic [11:0] addr, input logic [63:0] data);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.addr = addr; e.data = data;
    ev_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [11:0] addr, input logic [63:0] data);
    ev_t e;
    if (ev_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: kind %0d addr %h data %h at cycle %0d, expected none",
               kind, addr, data, cyc);
    end else begin
      e = ev_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_addr", addr, e.addr);
      chk("ev_data", data, e.data);
    end
  endtask

  // Monitor: compare every DUT output event against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_q.size() > 0) chk("hold_pipe", hold_pipe_o, hold_q.pop_front());
      if (int_ack_o)        expect_ev(K_ACK, 12'h0, 64'h0);
      if (clint_csr_wen_o)  expect_ev(K_WR, clint_csr_waddr_o, clint_csr_wdata_o);
      if (redirect_valid_o) expect_ev(K_RD, 12'h0, redirect_pc_o);
      if (!hold_pipe_o) begin
        chk("idle_waddr", clint_csr_waddr_o, 12'h0);
        chk("idle_wdata", clint_csr_wdata_o, 64'h0);
      end
    end
  end

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference rules for the mstatus rewrites, written as mask arithmetic.
  function automatic logic [63:0] ms_enter(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | (((m >> 3) & 64'h1) << 7);
  endfunction
  function automatic logic [63:0] ms_ret(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1880 | (((m >> 7) & 64'h1) << 3);
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    inst_valid_i = $urandom_range(0, 1);
    ecall_i = 0; mret_i = 0; global_int_en_i = 0;
    mtime_int_en_i = $urandom_range(0, 1); mtime_int_pend_i = $urandom_range(0, 1);
    inst_pc_i = r64();
    cpu_csr_wen_i = $urandom_range(0, 1);
    hold_q.push_back(1'b0);
  endtask

  // kind: 0 timer irq, 1 ecall, 2 mret, 3 timer irq + ecall together.
  task automatic run_txn(input int kind, input logic [63:0] pc, input logic [63:0] mtvec,
                         input logic [63:0] mstatus, input logic [63:0] mepc,
                         input bit rnd, input logic [7:0] cmask);
    bit          is_int;
    logic [63:0] cause, tgt;
    ev_t         wq[$];
    ev_t         w;
    bit          cw;
    int          k;
    is_int = (kind == 0 || kind == 3);
    cause  = is_int ? 64'h8000_0000_0000_0007 : 64'hB;
    @(posedge clk); #1;
    inst_valid_i = 1; inst_pc_i = pc;
    csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = mstatus;
    ecall_i = (kind == 1 || kind == 3);
    mret_i  = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    if (is_int) begin
      global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
    end else begin
      global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
      case ($urandom_range(0, 2))
        0: global_int_en_i = 0;
        1: mtime_int_en_i = 0;
        default: mtime_int_pend_i = 0;
      endcase
    end
    cpu_csr_wen_i = $urandom_range(0, 1);
    hold_q.push_back(1'b1);
    if (is_int) push_ev(K_ACK, 12'h0, 64'h0);

    if (kind == 2) begin
      w.kind = K_WR; w.addr = 12'h300; w.data = ms_ret(mstatus); wq.push_back(w);
      tgt = mepc;
    end else begin
      w.kind = K_WR; w.addr = 12'h341; w.data = pc;              wq.push_back(w);
      w.addr = 12'h342; w.data = cause;                           wq.push_back(w);
      w.addr = 12'h300; w.data = ms_enter(mstatus);               wq.push_back(w);
      tgt = mtvec - (mtvec % 4);
      if (is_int && (mtvec % 4) == 1) tgt = tgt + 4 * (cause & 64'h7FFF_FFFF_FFFF_FFFF);
    end

    k = 0;
    forever begin
      @(posedge clk); #1;
      // Triggers arriving mid-sequence must be ignored.
      inst_valid_i = $urandom_range(0, 1); inst_pc_i = r64();
      ecall_i = $urandom_range(0, 1); mret_i = $urandom_range(0, 1);
      global_int_en_i = $urandom_range(0, 1); mtime_int_en_i = $urandom_range(0, 1);
      mtime_int_pend_i = $urandom_range(0, 1);
      if (rnd) cw = ($urandom_range(0, 9) < 3) && (k < 30);
      else     cw = (k < 8) ? cmask[k[2:0]] : 1'b0;
      cpu_csr_wen_i = cw;
      hold_q.push_back(1'b1);
      if (wq.size() > 0) begin
        if (!cw) begin
          w = wq.pop_front();
          push_ev(K_WR, w.addr, w.data);
        end
      end else begin
        push_ev(K_RD, 12'h0, tgt);
        break;
      end
      k++;
    end
  endtask

  initial begin
    rst_n = 0; inst_valid_i = 0; inst_pc_i = 0; ecall_i = 0; mret_i = 0;
    global_int_en_i = 0; mtime_int_en_i = 0; mtime_int_pend_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0; cpu_csr_wen_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", clint_csr_wen_o, 1'b0);
    chk("rst_waddr", clint_csr_waddr_o, 12'h0);
    chk("rst_wdata", clint_csr_wdata_o, 64'h0);
    chk("rst_hold", hold_pipe_o, 1'b0);
    chk("rst_redirect", redirect_valid_o, 1'b0);
    chk("rst_redirect_pc", redirect_pc_o, 64'h0);
    chk("rst_int_ack", int_ack_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1;

    // Directed cases.
    run_txn(0, 64'h8000_0010, 64'h8000_1000, 64'h1888, 64'h0, 0, 8'h00);
    idle_cycle();
    run_txn(1, 64'h8000_0020, 64'h8000_1000, 64'h1888, 64'h0, 0, 8'h00);
    idle_cycle();
    run_txn(0, 64'h8000_0030, 64'h8000_1001, 64'h1888, 64'h0, 0, 8'h00);
    idle_cycle();
    run_txn(2, 64'h8000_0040, 64'h8000_1000, 64'h1880, 64'h8000_0014, 0, 8'h00);
    idle_cycle();
    run_txn(3, 64'h8000_0050, 64'h8000_1000, 64'h1888, 64'h0, 0, 8'b0000_0010);
    run_txn(1, 64'h8000_0060, 64'h8000_1001, 64'h0, 64'h0, 0, 8'h00);

    // Reset during W_MCAUSE: mepc is written, mcause write is blocked, sequence aborts.
    idle_cycle();
    @(posedge clk); #1;
    inst_valid_i = 1; inst_pc_i = 64'h8000_0070; ecall_i = 1; mret_i = 0;
    global_int_en_i = 0; cpu_csr_wen_i = 0;
    csr_mtvec_i = 64'h8000_1000; csr_mstatus_i = 64'h1888;
    hold_q.push_back(1'b1);
    @(posedge clk); #1;
    inst_valid_i = 0; ecall_i = 0;
    hold_q.push_back(1'b1);
    push_ev(K_WR, 12'h341, 64'h8000_0070);
    @(posedge clk); #1;
    rst_n = 0; cpu_csr_wen_i = 1;
    hold_q.push_back(1'b1);
    @(posedge clk); #1;
    rst_n = 1; cpu_csr_wen_i = 0;
    @(negedge clk);
    chk("post_rst_hold", hold_pipe_o, 1'b0);
    chk("post_rst_wen", clint_csr_wen_o, 1'b0);
    chk("post_rst_wdata", clint_csr_wdata_o, 64'h0);
    chk("post_rst_redirect", redirect_valid_o, 1'b0);
    chk("post_rst_redirect_pc", redirect_pc_o, 64'h0);
    chk("post_rst_int_ack", int_ack_o, 1'b0);

    // Randomized traffic with random write-port conflicts.
    for (int i = 0; i < 150; i++) begin
      logic [63:0] tv;
      tv = r64();
      tv[1:0] = 2'($urandom_range(0, 3));
      run_txn($urandom_range(0, 3), r64(), tv, r64(), r64(), 1, 8'h00);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    repeat (3) idle_cycle();
    @(negedge clk);
    chk("scoreboard_drained", ev_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
